// File: rtl/ifu_pkg.sv
// ifu_pkg: shared widths, PC bounds, FSM states and prefetch entry type for the fetch unit
package ifu_pkg;
  localparam int ADDR_W = 16;
  localparam int INSTR_W = 16;
  localparam logic [ADDR_W-1:0] RESET_PC = 16'h0000;
  localparam logic [ADDR_W-1:0] PC_LIMIT = 16'h2000;
  localparam logic [ADDR_W-1:0] PC_MAX = PC_LIMIT - 1'b1;
  typedef enum logic [1:0] {IDLE, RUN, HOLD} ifu_state_t;
  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/ifu_prefetch_fifo.sv
// ifu_prefetch_fifo: synchronous FIFO of fetch entries; flush beats push, head reads 0 when empty
module ifu_prefetch_fifo
  import ifu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  fetch_entry_t               din,
  output fetch_entry_t               head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);
  fetch_entry_t mem [DEPTH];
  logic [AW:0] wp, rp;
  logic do_push, do_pop;
  assign count = wp - rp;
  assign empty = count == '0;
  assign full = count == (AW+1)'(DEPTH);
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head = empty ? '0 : mem[rp[AW-1:0]];
  // pointer bookkeeping; the extra MSB separates full from empty
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
    end
  end
  // storage has no reset; validity is tracked purely by the pointers
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wp[AW-1:0]] <= din;
  end
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: owns the PC, issues instruction-memory reads and feeds decode through a prefetch FIFO
module instr_fetch_unit
  import ifu_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic [ADDR_W-1:0]  A_InstrAddress,
  output logic               C_IMRead,
  input  logic [INSTR_W-1:0] D_Instruction,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr_data,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               instr_ready
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  ifu_state_t state;
  logic [ADDR_W-1:0] pc;
  logic [CW-1:0] count;
  logic full, empty, pop, fills;
  fetch_entry_t head;
  assign pop = instr_valid && instr_ready;
  assign instr_valid = !empty;
  assign instr_data = head.instr;
  assign instr_pc = head.pc;
  assign A_InstrAddress = pc;
  assign C_IMRead = state != IDLE && !redirect_valid && (!full || pop);
  assign fills = C_IMRead && !pop && count == CW'(FIFO_DEPTH - 1);
  ifu_prefetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (C_IMRead),
    .pop   (pop),
    .flush (redirect_valid),
    .din   ('{pc: pc, instr: D_Instruction}),
    .head  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );
  // fetch FSM: enable gates everything, HOLD marks a full FIFO that decode is not draining
  always_ff @(posedge clk) begin
    if (rst || !en) state <= IDLE;
    else state <= state == IDLE ? RUN :
                  state == HOLD ? ((pop || redirect_valid) ? RUN : HOLD) :
                  (fills ? HOLD : RUN);
  end
  // PC advances per issued read and wraps at the memory size; redirects are folded into range
  always_ff @(posedge clk) begin
    if (rst) pc <= RESET_PC;
    else if (redirect_valid) pc <= redirect_pc % PC_LIMIT;
    else if (C_IMRead) pc <= pc == PC_MAX ? '0 : pc + 1'b1;
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed scenarios plus random traffic against a queue-based fetch model
module tb_instr_fetch_unit;
  localparam int DEPTH = 2;
  localparam int LIMIT = 'h2000;
  logic clk = 1'b0;
  logic rst = 1'b0, en = 1'b0, redirect_valid = 1'b0, instr_ready = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic C_IMRead, instr_valid;
  logic [15:0] A_InstrAddress, D_Instruction, instr_data, instr_pc;
  int checks = 0, failures = 0;
  bit chk_on = 0;
  int q_pc[$], q_in[$];
  bit act = 0;
  int mpc = 0;

  always #5 clk = ~clk;
  assign D_Instruction = 16'hA000 + A_InstrAddress;

  instr_fetch_unit #(.FIFO_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .en             (en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .A_InstrAddress (A_InstrAddress),
    .C_IMRead       (C_IMRead),
    .D_Instruction  (D_Instruction),
    .instr_valid    (instr_valid),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready)
  );

  task automatic cmp(input string n, input logic [15:0] a, input logic [15:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", n, a, e, $time);
    end
  endtask

  task automatic cyc(input bit r, input bit e, input bit rv, input logic [15:0] rp, input bit rdy);
    bit v, full, pop, rd;
    @(posedge clk);
    #1;
    rst = r; en = e; redirect_valid = rv; redirect_pc = rp; instr_ready = rdy;
    @(negedge clk);
    v = q_pc.size() > 0;
    full = q_pc.size() == DEPTH;
    pop = v && rdy;
    rd = act && !rv && (!full || pop);
    if (chk_on) begin
      cmp("C_IMRead", 16'(C_IMRead), 16'(rd));
      cmp("A_InstrAddress", A_InstrAddress, 16'(mpc));
      cmp("instr_valid", 16'(instr_valid), 16'(v));
      cmp("instr_data", instr_data, v ? 16'(q_in[0]) : 16'h0);
      cmp("instr_pc", instr_pc, v ? 16'(q_pc[0]) : 16'h0);
    end
    if (r) begin
      q_pc.delete(); q_in.delete(); mpc = 0; act = 0;
    end else begin
      if (pop) begin
        void'(q_pc.pop_front());
        void'(q_in.pop_front());
      end
      if (rv) begin
        q_pc.delete(); q_in.delete(); mpc = int'(rp) % LIMIT;
      end else if (rd) begin
        q_pc.push_back(mpc);
        q_in.push_back((32'hA000 + mpc) & 32'hFFFF);
        mpc = (mpc + 1) % LIMIT;
      end
      act = e;
    end
    chk_on = 1;
  endtask

  task automatic fill();
    cyc(1, 1, 0, 16'h0, 0);
    repeat (4) cyc(0, 1, 0, 16'h0, 0);
  endtask

  initial begin
    cyc(1, 1, 0, 16'h0, 1);
    cyc(0, 1, 0, 16'h0, 1);
    cmp("pin_rst_rd", 16'(C_IMRead), 16'h0);
    cmp("pin_rst_addr", A_InstrAddress, 16'h0000);
    cmp("pin_rst_valid", 16'(instr_valid), 16'h0);
    cmp("pin_rst_data", instr_data, 16'h0);
    cmp("pin_rst_pc", instr_pc, 16'h0);
    cyc(0, 1, 0, 16'h0, 1);
    cmp("pin_t1_rd", 16'(C_IMRead), 16'h1);
    cyc(0, 1, 0, 16'h0, 1);
    cmp("pin_t1_d0", instr_data, 16'hA000);
    cmp("pin_t1_addr1", A_InstrAddress, 16'h0001);
    cyc(0, 1, 0, 16'h0, 1);
    cmp("pin_t1_d1", instr_data, 16'hA001);
    cmp("pin_t1_p1", instr_pc, 16'h0001);
    fill();
    cmp("pin_t2_full_rd", 16'(C_IMRead), 16'h0);
    cmp("pin_t2_head", instr_data, 16'hA000);
    repeat (3) cyc(0, 1, 0, 16'h0, 0);
    cmp("pin_t2_stable", instr_data, 16'hA000);
    cyc(0, 1, 0, 16'h0, 1);
    cmp("pin_t2_pop0", instr_data, 16'hA000);
    cmp("pin_t2_rd", 16'(C_IMRead), 16'h1);
    cyc(0, 1, 0, 16'h0, 1);
    cmp("pin_t2_pop1", instr_data, 16'hA001);
    cyc(0, 1, 0, 16'h0, 1);
    cmp("pin_t2_pop2", instr_data, 16'hA002);
    fill();
    cyc(0, 1, 1, 16'h0100, 0);
    cmp("pin_t3_rd", 16'(C_IMRead), 16'h0);
    cyc(0, 1, 0, 16'h0, 0);
    cmp("pin_t3_valid", 16'(instr_valid), 16'h0);
    cmp("pin_t3_addr", A_InstrAddress, 16'h0100);
    cyc(0, 1, 0, 16'h0, 0);
    cmp("pin_t3_data", instr_data, 16'hA100);
    cmp("pin_t3_pc", instr_pc, 16'h0100);
    cyc(0, 1, 1, 16'h1FFF, 1);
    cyc(0, 1, 0, 16'h0, 1);
    cmp("pin_t4_addr", A_InstrAddress, 16'h1FFF);
    cyc(0, 1, 0, 16'h0, 1);
    cmp("pin_t4_data", instr_data, 16'hBFFF);
    cmp("pin_t4_wrap", A_InstrAddress, 16'h0000);
    cyc(0, 1, 0, 16'h0, 1);
    cmp("pin_t4_data0", instr_data, 16'hA000);
    cmp("pin_t4_pc0", instr_pc, 16'h0000);
    cyc(0, 0, 0, 16'h0, 1);
    cmp("pin_t5_rd_late", 16'(C_IMRead), 16'h1);
    cyc(0, 0, 0, 16'h0, 1);
    cmp("pin_t5_rd_off", 16'(C_IMRead), 16'h0);
    cyc(0, 0, 0, 16'h0, 1);
    cmp("pin_t5_drained", 16'(instr_valid), 16'h0);
    cyc(0, 1, 0, 16'h0, 1);
    cyc(0, 1, 0, 16'h0, 1);
    cmp("pin_t5_resume", 16'(C_IMRead), 16'h1);
    fill();
    cyc(1, 1, 1, 16'h0055, 0);
    cyc(0, 1, 0, 16'h0, 0);
    cmp("pin_t6_valid", 16'(instr_valid), 16'h0);
    cmp("pin_t6_addr", A_InstrAddress, 16'h0000);
    cmp("pin_t6_rd", 16'(C_IMRead), 16'h0);
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] rp;
      rp = ($urandom_range(0, 3) == 0) ? 16'(LIMIT - 1 - $urandom_range(0, 2)) :
           ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 255));
      cyc($urandom_range(0, 199) == 0, $urandom_range(0, 9) != 0,
          $urandom_range(0, 15) == 0, rp, $urandom_range(0, 2) != 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
